// File: rtl/spi_burst_master.sv
// SPI mode-3 burst master: internal SCLK divider, one command word then 1..MAX_BYTES data bytes.
// Optional SPI_MB_AUTO_EN: force the multi-byte command bit on reads longer than one byte.
module spi_burst_master #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 6,
  parameter int CLK_DIV   = 4,
  localparam int NB_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic              spi_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [NB_W-1:0]   nbytes,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic [NB_W-1:0]   rx_index,
  output logic              SPI_SDI,
  input  logic              SPI_SDO,
  output logic              SPI_CSN,
  output logic              SPI_CLK
);

  localparam int TOT_MAX = ADDR_W + MAX_BYTES * DATA_W;
  localparam int BC_W    = $clog2(TOT_MAX + 1);
  localparam int DIV_W   = $clog2(CLK_DIV + 1);
  localparam int DB_W    = $clog2(DATA_W + 1);
  localparam int TX_W    = ADDR_W + DATA_W;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_t;

  state_t            state_q;
  logic              csn_q, sclk_q, sdi_q, busy_q, done_q, rx_valid_q;
  logic [DATA_W-1:0] rx_data_q, rx_sh_q;
  logic [NB_W-1:0]   rx_index_q, rx_cnt_q;
  logic [DIV_W-1:0]  div_cnt_q;
  logic [BC_W-1:0]   bit_cnt_q, last_q;
  logic [DB_W-1:0]   dbit_cnt_q;
  logic [TX_W-1:0]   tx_q;
  logic              phase_q, rw_q;

  logic [NB_W-1:0]   len_d;
  logic [ADDR_W-1:0] cmd_d;
  logic [BC_W-1:0]   last_d;
  logic [DATA_W-1:0] rx_sh_d;
  logic              half_end, sample_now;

  always_comb begin
    if (!rw || nbytes == '0)              len_d = NB_W'(1);
    else if (nbytes > NB_W'(MAX_BYTES))   len_d = NB_W'(MAX_BYTES);
    else                                  len_d = nbytes;
    cmd_d = addr;
    cmd_d[ADDR_W-1] = rw;
`ifdef SPI_MB_AUTO_EN
    if (rw && len_d > NB_W'(1)) cmd_d[ADDR_W-2] = 1'b1;
`endif
    last_d     = BC_W'(ADDR_W - 1) + BC_W'(len_d) * BC_W'(DATA_W);
    rx_sh_d    = (rx_sh_q << 1) | DATA_W'(SPI_SDO);
    half_end   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    // SDO is taken on the first cycle SCLK is visibly high, i.e. one edge after it rises
    sample_now = (state_q == S_SHIFT) && phase_q && (div_cnt_q == '0) && rw_q &&
                 (bit_cnt_q >= BC_W'(ADDR_W));
  end

  always_ff @(posedge spi_clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      csn_q      <= 1'b1;
      sclk_q     <= 1'b1;
      sdi_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_sh_q    <= '0;
      rx_index_q <= '0;
      rx_cnt_q   <= '0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      last_q     <= '0;
      dbit_cnt_q <= '0;
      tx_q       <= '0;
      phase_q    <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      if (sample_now) begin
        if (dbit_cnt_q == DB_W'(DATA_W - 1)) begin
          rx_data_q  <= rx_sh_d;
          rx_valid_q <= 1'b1;
          rx_index_q <= rx_cnt_q;
          rx_cnt_q   <= rx_cnt_q + NB_W'(1);
          dbit_cnt_q <= '0;
        end else begin
          dbit_cnt_q <= dbit_cnt_q + DB_W'(1);
        end
        rx_sh_q <= rx_sh_d;
      end
      case (state_q)
        S_IDLE: begin
          csn_q  <= 1'b1;
          sclk_q <= 1'b1;
          sdi_q  <= 1'b1;
          if (start) begin
            state_q    <= S_SETUP;
            csn_q      <= 1'b0;
            busy_q     <= 1'b1;
            rw_q       <= rw;
            last_q     <= last_d;
            tx_q       <= rw ? {cmd_d, {DATA_W{1'b1}}} : {cmd_d, wdata};
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            dbit_cnt_q <= '0;
            rx_cnt_q   <= '0;
            rx_sh_q    <= '0;
            phase_q    <= 1'b0;
          end
        end
        S_SETUP: begin
          if (half_end) begin
            div_cnt_q <= '0;
            state_q   <= S_SHIFT;
            sclk_q    <= 1'b0;
            sdi_q     <= tx_q[TX_W-1];
            tx_q      <= {tx_q[TX_W-2:0], 1'b1};
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end
        S_SHIFT: begin
          div_cnt_q <= half_end ? '0 : div_cnt_q + DIV_W'(1);
          if (half_end) begin
            if (!phase_q) begin
              phase_q <= 1'b1;
              sclk_q  <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              if (bit_cnt_q == last_q) begin
                state_q <= S_HOLD;
              end else begin
                bit_cnt_q <= bit_cnt_q + BC_W'(1);
                sclk_q    <= 1'b0;
                sdi_q     <= tx_q[TX_W-1];
                tx_q      <= {tx_q[TX_W-2:0], 1'b1};
              end
            end
          end
        end
        S_HOLD: begin
          if (half_end) begin
            div_cnt_q <= '0;
            state_q   <= S_DONE;
            csn_q     <= 1'b1;
            sdi_q     <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_index = rx_index_q;
  assign SPI_SDI  = sdi_q;
  assign SPI_CSN  = csn_q;
  assign SPI_CLK  = sclk_q;

endmodule

// File: tb/tb_spi_burst_master.sv
// Bench for spi_burst_master: vector table of transactions with an SPI slave model and rx scoreboard.
module tb_spi_burst_master;

  localparam int CLK_DIV = 2;
`ifdef SPI_MB_AUTO_EN
  localparam logic MB = 1'b1;
`else
  localparam logic MB = 1'b0;
`endif

  logic       spi_clk = 1'b0;
  logic       reset, start, rw;
  logic [7:0] addr, wdata;
  logic [2:0] nbytes;
  logic       busy, done, rx_valid;
  logic [7:0] rx_data;
  logic [2:0] rx_index;
  logic       SPI_SDI, SPI_SDO, SPI_CSN, SPI_CLK;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [2:0] nb;
    logic [7:0] wd;
    logic [7:0] base;
    logic [7:0] cmd;
    int         len;
  } vec_t;

  vec_t vecs[8];

  spi_burst_master #(.ADDR_W(8), .DATA_W(8), .MAX_BYTES(6), .CLK_DIV(CLK_DIV)) dut (
    .spi_clk(spi_clk), .reset(reset), .start(start), .rw(rw), .addr(addr),
    .nbytes(nbytes), .wdata(wdata), .busy(busy), .done(done), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_index(rx_index), .SPI_SDI(SPI_SDI), .SPI_SDO(SPI_SDO),
    .SPI_CSN(SPI_CSN), .SPI_CLK(SPI_CLK)
  );

  always #5 spi_clk = ~spi_clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives one transaction, plays the slave, and checks the wire-level result.
  task automatic run_txn(input logic rw_v, input logic [7:0] addr_v, input logic [2:0] nb_v,
                         input logic [7:0] wd_v, input logic [7:0] base, input logic [7:0] exp_cmd,
                         input int exp_len, input int mid_at, input bit abort);
    int cyc, ncap, fc, csn_cnt, ndone, nrx, exp_bits, abort_cnt;
    logic [63:0] cap, tmp, mask;
    logic [15:0] e;
    logic [7:0]  b;
    logic        prev_sclk, aborted;
    cap = '0; ncap = 0; fc = 0; csn_cnt = 0; ndone = 0; nrx = 0; abort_cnt = 0;
    prev_sclk = 1'b1; aborted = 1'b0;
    exp_bits = 8 + 8 * exp_len;
    if (rw_v)
      for (int k = 0; k < exp_len; k++) exp_q.push_back({8'(k), 8'(base + 8'h11 * k)});
    @(negedge spi_clk);
    rw = rw_v; addr = addr_v; nbytes = nb_v; wdata = wd_v; start = 1'b1;
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge spi_clk);
      cyc++;
      start = (mid_at > 0 && cyc == mid_at);
      if (!SPI_CSN) csn_cnt++;
      if (SPI_CLK && !prev_sclk && !SPI_CSN) begin
        cap = {cap[62:0], SPI_SDI};
        ncap++;
      end
      if (!SPI_CLK && prev_sclk && !SPI_CSN) begin
        if (fc >= 8) begin
          b = 8'(base + 8'h11 * ((fc - 8) / 8));
          SPI_SDO = b[7 - ((fc - 8) % 8)];
        end
        fc++;
      end
      prev_sclk = SPI_CLK;
      if (rx_valid) begin
        nrx++;
        if (exp_q.size() == 0) check("rx_unexpected", 64'(nrx), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("rx_data", rx_data, e[7:0]);
          check("rx_index", rx_index, e[15:8]);
        end
      end
      if (done) begin
        ndone++;
        check("busy_low_with_done", busy, 0);
        break;
      end
      if (abort && nrx == 2) begin
        abort_cnt++;
        if (abort_cnt == 12) begin
          reset = 1'b0;
          @(negedge spi_clk);
          reset = 1'b1;
          check("abort_csn", SPI_CSN, 1);
          check("abort_sclk", SPI_CLK, 1);
          check("abort_busy", busy, 0);
          check("abort_rx_data", rx_data, 0);
          check("abort_rx_index", rx_index, 0);
          check("abort_done", done, 0);
          aborted = 1'b1;
          break;
        end
      end
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge spi_clk);
      if (!SPI_CSN) csn_cnt++;
      if (done) ndone++;
      if (rx_valid) nrx++;
    end
    if (aborted) begin
      check("abort_no_done", ndone, 0);
      check("abort_idle_csn", SPI_CSN, 1);
      exp_q.delete();
    end else begin
      check("done_count", ndone, 1);
      check("bit_count", ncap, exp_bits);
      tmp = cap >> (ncap - 8);
      check("cmd", tmp[7:0], exp_cmd);
      check("csn_low_cycles", csn_cnt, CLK_DIV * (2 + 2 * exp_bits));
      check("rx_count", nrx, rw_v ? exp_len : 0);
      check("scoreboard_empty", exp_q.size(), 0);
      if (rw_v) begin
        mask = (64'd1 << (8 * exp_len)) - 64'd1;
        check("read_sdi_high", cap & mask, mask);
      end else begin
        check("wdata", cap[7:0], wd_v);
      end
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h2D, 3'd3, 8'h08, 8'h00, 8'h2D, 1};
    vecs[1] = '{1'b0, 8'hC5, 3'd0, 8'hA5, 8'h00, 8'h45, 1};
    vecs[2] = '{1'b1, 8'h00, 3'd1, 8'h00, 8'hE5, 8'h80, 1};
    vecs[3] = '{1'b1, 8'h32, 3'd6, 8'h00, 8'h11, MB ? 8'hF2 : 8'hB2, 6};
    vecs[4] = '{1'b1, 8'h0F, 3'd0, 8'h00, 8'h3C, 8'h8F, 1};
    vecs[5] = '{1'b1, 8'h32, 3'd7, 8'h00, 8'h11, MB ? 8'hF2 : 8'hB2, 6};
    vecs[6] = '{1'b1, 8'h05, 3'd2, 8'h00, 8'hA0, MB ? 8'hC5 : 8'h85, 2};
    vecs[7] = '{1'b1, 8'h7F, 3'd1, 8'h00, 8'h5A, 8'hFF, 1};

    reset = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; nbytes = '0; wdata = '0; SPI_SDO = 1'b1;
    repeat (3) @(negedge spi_clk);
    check("rst_csn", SPI_CSN, 1);
    check("rst_sclk", SPI_CLK, 1);
    check("rst_sdi", SPI_SDI, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_index", rx_index, 0);
    reset = 1'b1;
    repeat (2) @(negedge spi_clk);

    for (int v = 0; v < 8; v++)
      run_txn(vecs[v].rw, vecs[v].addr, vecs[v].nb, vecs[v].wd, vecs[v].base,
              vecs[v].cmd, vecs[v].len, 0, 1'b0);

    // start re-pulsed mid-SHIFT must be ignored
    run_txn(1'b1, 8'h0A, 3'd2, 8'h00, 8'h77, MB ? 8'hCA : 8'h8A, 2, 30, 1'b0);
    // reset in the third data byte, then a normal transaction
    run_txn(1'b1, 8'h32, 3'd6, 8'h00, 8'h11, MB ? 8'hF2 : 8'hB2, 6, 0, 1'b1);
    run_txn(vecs[2].rw, vecs[2].addr, vecs[2].nb, vecs[2].wd, vecs[2].base,
            vecs[2].cmd, vecs[2].len, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_burst_master.md
# spi_burst_master

Parametrised SPI mode-3 master for the accelerometer path. It replaces the fixed 16-bit serializer with one that generates SCLK internally from a single clock and supports multi-byte burst reads: 1 to MAX_BYTES data bytes per chip-select, with each received byte streamed out on a valid strobe. It sits between the accelerometer register-sequencer FSM and the SPI pins.

## Interface
- ADDR_W, 8: width of the command/address phase in bits; ≥2.
- DATA_W, 8: width of each data byte in bits.
- MAX_BYTES, 6: maximum burst-read length.
- CLK_DIV, 4: SCLK half-period in spi_clk cycles; ≥1.
- NB_W, $clog2(MAX_BYTES+1): width of nbytes (localparam).

Ports:
- spi_clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- rw  in  1  1 = read, 0 = write.
- addr  in  ADDR_W  command/address word; sent MSB first, with rw forced into bit ADDR_W-1.
- nbytes  in  NB_W  read burst length; ignored for writes.
- wdata  in  DATA_W  write data byte.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at the end of a transaction.
- rx_valid  out  1  one-cycle pulse per received byte.
- rx_data  out  DATA_W  received byte; valid when rx_valid is high and held until the next byte.
- rx_index  out  NB_W  index of the byte in rx_data, counted from 0.
- SPI_SDI  out  1  MOSI.
- SPI_SDO  in  1  MISO.
- SPI_CSN  out  1  chip select, active low.
- SPI_CLK  out  1  SCLK; idles high.

## Operation
- States: IDLE → SETUP → SHIFT → HOLD → DONE → IDLE.
- IDLE: CSN=1, SCLK=1, SDI=1.
  - On start=1, latch the command {rw, addr[ADDR_W-2:0]}, wdata and the effective length.
  - Effective length: nbytes=0 → 1; nbytes>MAX_BYTES → MAX_BYTES; write → 1.
  - Clear the bit counter, then go to SETUP.
- SETUP: CSN=0, SCLK=1 for CLK_DIV cycles, then SHIFT.
- SHIFT: one bit per 2·CLK_DIV cycles.
  - First half of each bit: SCLK=0, and SDI presents the current bit. SDI changes only on the falling edge.
  - Second half: SCLK=1. SDO is sampled in the cycle where SCLK rises.
  - Total bits = ADDR_W + len·DATA_W.
  - Read: after the ADDR_W command bits, SDI=1 and SDO is shifted MSB-first into a DATA_W shift register.
  - On each DATA_W-th sampled data bit: copy the shift register to rx_data, pulse rx_valid on the next cycle, and increment rx_index.
  - Write: wdata follows the command MSB-first. rx_valid never pulses.
  - After the second half of the last bit, go to HOLD.
- HOLD: CSN=0, SCLK=1 for CLK_DIV cycles, then DONE.
- DONE: CSN=1, done=1 for one cycle, then IDLE. busy falls in the same cycle as done.
- start is ignored while busy=1; no queuing.
- A new start is accepted in the IDLE cycle that follows DONE. Minimum CSN-high time is 2 cycles.
- Reset (synchronous, checked every edge, including mid-transfer):
  - state=IDLE, CSN=1, SCLK=1, SDI=1.
  - busy=0, done=0, rx_valid=0, rx_data=0, rx_index=0, counters=0.
  - A partially received byte is discarded.

## Timing
- start accepted at edge N → CSN low at N+1.
- CSN-low duration = CLK_DIV·(2 + 2·bits) cycles.
- done is high in the cycle immediately after CSN rises.
- rx_valid for byte k is asserted one cycle after the SCLK rising edge that samples that byte's LSB. It precedes done for the last byte.
- SCLK frequency = f(spi_clk)/(2·CLK_DIV). All outputs are registered and glitch-free.

## Configuration
- SPI_MB_AUTO_EN:
  - Defined: on a read with an effective length >1, bit ADDR_W-2 of the sent command is forced to 1. This is the accelerometer multi-byte bit.
  - Not defined: bit ADDR_W-2 is sent exactly as given in addr.
  - Writes and single-byte reads are unaffected in both cases.

## Test plan
- Write, CLK_DIV=2, rw=0, addr=0x2D, wdata=0x08 → SDI sequence 0x2D then 0x08 MSB-first. CSN low for 2·(2+32)=68 cycles. No rx_valid; one done pulse.
- Single read, rw=1, addr=0x00, slave returns 0xE5 → command bits 0x80. One rx_valid with rx_data=0xE5 and rx_index=0, then done.
- Burst read, rw=1, addr=0x32, nbytes=6, slave returns 0x11..0x66, macro defined → command 0xF2 (0xB2 without the macro). Six rx_valid pulses carrying 0x11..0x66 with rx_index 0..5, then done.
- Length clamping: nbytes=0 → 1 byte; nbytes=7 with MAX_BYTES=6 → 6 bytes. CSN-low duration matches the formula in each case.
- start pulsed again during SHIFT → ignored. The transaction and bit count are unchanged; exactly one done.
- reset=0 during the 3rd data byte → next edge: CSN=1, SCLK=1, busy=0, rx_data=0, no done. A following start completes normally.
